// File: rtl/mlp_pkg.sv
// Shared types, constants and helpers for the MLP datapath blocks.
// Words are signed-magnitude: bit N-1 is the sign, the rest the magnitude
// with F fraction bits.
package mlp_pkg;

    localparam int N         = 16;
    localparam int F         = 8;
    localparam int ACC_GUARD = 3;

    localparam logic [N-2:0] SM_MAX = '1;

    typedef logic [N-1:0] sm_t;
    typedef logic signed [2*N+ACC_GUARD-1:0] acc_t;

    typedef enum logic [1:0] {
        ST_ACC,
        ST_MUL_DRAIN,
        ST_ACC_DRAIN,
        ST_OUT
    } layer_state_e;

    // Bias arrives with F fraction bits; the accumulator works with 2*F, so
    // the magnitude is shifted up before the sign is applied. A negative
    // zero collapses to plain zero through the negation.
    function automatic logic signed [2*N-1:0] sm_to_tc(input sm_t v);
        logic signed [2*N-1:0] mag;
        mag = $signed({{(N+1){1'b0}}, v[N-2:0]} << F);
        if (v[N-1]) begin
            return -mag;
        end
        return mag;
    endfunction

endpackage

// File: rtl/sm_mul_tc.sv
// Combinational signed-magnitude multiplier giving a two's-complement
// product with 2*F fraction bits. A zero magnitude always yields +0.
module sm_mul_tc
    import mlp_pkg::*;
(
    input  sm_t                      i_a,
    input  sm_t                      i_b,
    output logic signed [2*N-1:0]    o_p
);

    logic [2*N-3:0] w_mag;
    logic           w_neg;

    // Multiply magnitudes, then negate only for a non-zero opposite-sign result.
    always_comb begin
        w_mag = i_a[N-2:0] * i_b[N-2:0];
        w_neg = (i_a[N-1] ^ i_b[N-1]) && (w_mag != '0);
        o_p   = w_neg ? -$signed({2'b00, w_mag}) : $signed({2'b00, w_mag});
    end

endmodule

// File: rtl/layer_mac.sv
// Fully-connected layer: one activation per beat is multiplied by each
// neuron's weight, accumulated on top of the bias, then rounded toward zero
// and saturated into a signed-magnitude output vector for the relu stage.
module layer_mac
    import mlp_pkg::*;
#(
    parameter int Size   = 3,
    parameter int MaxLen = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    output logic in_ready,
    input  logic in_last,
    input  sm_t  x,
    input  sm_t  w [0:Size-1],
    input  sm_t  b [0:Size-1],
    output logic out_valid,
    input  logic out_ready,
    output sm_t  c [0:Size-1]
);

    localparam int AccW = 2*N + $clog2(MaxLen);

    layer_state_e r_state;
    layer_state_e w_nextState;
    logic         w_beatAcc;
    logic         r_first;
    logic         r_pValid;

    assign w_beatAcc = in_valid && in_ready;

    // State register; reset abandons any partially accumulated vector.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_ACC;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and handshake outputs; in_ready stays low while in reset.
    always_comb begin
        w_nextState = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            ST_ACC: begin
                in_ready = rst_n;
                if (in_valid && rst_n && in_last) begin
                    w_nextState = ST_MUL_DRAIN;
                end
            end
            ST_MUL_DRAIN: w_nextState = ST_ACC_DRAIN;
            ST_ACC_DRAIN: w_nextState = ST_OUT;
            ST_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_nextState = ST_ACC;
                end
            end
            default: w_nextState = ST_ACC;
        endcase
    end

    // Tracks whether the next beat starts a vector and whether stage 1 holds a product.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_first  <= 1'b1;
            r_pValid <= 1'b0;
        end else begin
            r_pValid <= w_beatAcc;
            if (w_beatAcc) begin
                r_first <= in_last;
            end
        end
    end

    for (genvar i = 0; i < Size; i++) begin : g_neuron
        logic signed [2*N-1:0]  w_p;
        logic signed [2*N-1:0]  r_p;
        logic signed [2*N-1:0]  w_bias;
        logic signed [AccW-1:0] r_acc;
        logic        [AccW-1:0] w_accMag;
        logic        [AccW-1:0] w_magTrunc;
        logic                   w_accNeg;
        sm_t                    w_cNext;
        sm_t                    r_c;

        sm_mul_tc u_mul (
            .i_a (x),
            .i_b (w[i]),
            .o_p (w_p)
        );

        assign w_bias = sm_to_tc(b[i]);

        // Stage 1 captures the product; stage 2 loads the bias on a first beat
        // or folds the previous beat's product into the running sum.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_p   <= '0;
                r_acc <= '0;
            end else begin
                if (w_beatAcc) begin
                    r_p <= w_p;
                end
                if (w_beatAcc && r_first) begin
                    r_acc <= {{(AccW-2*N){w_bias[2*N-1]}}, w_bias};
                end else if (r_pValid) begin
                    r_acc <= r_acc + {{(AccW-2*N){r_p[2*N-1]}}, r_p};
                end
            end
        end

        // Truncate the magnitude toward zero, clamp to the largest word, never emit -0.
        always_comb begin
            w_accNeg   = r_acc[AccW-1];
            w_accMag   = w_accNeg ? unsigned'(-r_acc) : unsigned'(r_acc);
            w_magTrunc = w_accMag >> F;
            w_cNext    = '0;
            if (w_magTrunc > {{(AccW-N+1){1'b0}}, SM_MAX}) begin
                w_cNext = {w_accNeg, SM_MAX};
            end else if (w_magTrunc != '0) begin
                w_cNext = {w_accNeg, w_magTrunc[N-2:0]};
            end
        end

        // Output word is refreshed once per vector and held through backpressure.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_c <= '0;
            end else if (r_state == ST_ACC_DRAIN) begin
                r_c <= w_cNext;
            end
        end

        assign c[i] = r_c;
    end

endmodule

// File: tb/tb_layer_mac.sv
// Self-checking bench for layer_mac: expected vectors are computed from the
// driven beats with a wide-integer reference and queued, then popped when the
// block presents each result.
module tb_layer_mac;
    import mlp_pkg::*;

    localparam int SZ = 3;

    logic clk       = 1'b0;
    logic rst_n     = 1'b0;
    logic in_valid  = 1'b0;
    logic in_last   = 1'b0;
    logic out_ready = 1'b0;
    logic in_ready;
    logic out_valid;
    sm_t  x = '0;
    sm_t  w [0:SZ-1];
    sm_t  b [0:SZ-1];
    sm_t  c [0:SZ-1];

    int checkCount = 0;
    int errorCount = 0;

    logic [SZ-1:0][15:0] expQ [$];
    sm_t beatX [8];
    sm_t beatW [8][SZ];
    sm_t vecB  [SZ];

    layer_mac #(.Size(SZ), .MaxLen(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .x         (x),
        .w         (w),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c)
    );

    always #5 clk = ~clk;

    function automatic longint sm_val(input sm_t v);
        longint m;
        m = longint'(v[14:0]);
        return v[15] ? -m : m;
    endfunction

    function automatic sm_t model_word(input longint acc);
        longint m;
        sm_t    r;
        m = (acc < 0) ? -acc : acc;
        m = m / 256;
        if (m > 32767) m = 32767;
        if (m == 0) return 16'h0000;
        r = {(acc < 0) ? 1'b1 : 1'b0, m[14:0]};
        return r;
    endfunction

    task automatic push_expected(input int n);
        logic [SZ-1:0][15:0] e;
        longint acc;
        for (int k = 0; k < SZ; k++) begin
            acc = sm_val(vecB[k]) * 256;
            for (int i = 0; i < n; i++) begin
                acc = acc + sm_val(beatX[i]) * sm_val(beatW[i][k]);
            end
            e[k] = model_word(acc);
        end
        expQ.push_back(e);
    endtask

    task automatic drive_beats(input int n, input bit lastOnFinal, output bit ok);
        int guard;
        ok = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            x        = beatX[i];
            for (int k = 0; k < SZ; k++) begin
                w[k] = beatW[i][k];
                b[k] = vecB[k];
            end
            in_last = lastOnFinal && (i == n - 1);
            guard = 0;
            while (!in_ready && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            if (!in_ready) ok = 1'b0;
            @(posedge clk);
        end
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_out(output bit ok, output int cycles);
        ok = 1'b0;
        cycles = 0;
        while (cycles < 20) begin
            @(negedge clk);
            cycles++;
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checkCount++;
        if (in_ready !== 1'b0) begin errorCount++; $display("[TB] FAIL reset_in_ready_low: got %b expected 0", in_ready); end
        checkCount++;
        if (out_valid !== 1'b0) begin errorCount++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
        rst_n = 1'b1;
        @(negedge clk);
        checkCount++;
        if (in_ready !== 1'b1) begin errorCount++; $display("[TB] FAIL reset_in_ready_high: got %b expected 1", in_ready); end
        for (int k = 0; k < SZ; k++) begin
            checkCount++;
            if (c[k] !== 16'h0000) begin errorCount++; $display("[TB] FAIL reset_c%0d: got %h expected 0000", k, c[k]); end
        end
    endtask

    task automatic test_basic();
        bit ok;
        int cyc;
        logic [SZ-1:0][15:0] e;
        vecB = '{16'h0000, 16'h0000, 16'h0000};
        beatX[0] = 16'h0100; beatW[0] = '{16'h0080, 16'h0100, 16'h8040};
        beatX[1] = 16'h0200; beatW[1] = '{16'h0040, 16'h8100, 16'h0020};
        push_expected(2);
        drive_beats(2, 1'b1, ok);
        checkCount++;
        if (!ok) begin errorCount++; $display("[TB] FAIL basic_accept: got timeout expected accepted"); end
        wait_out(ok, cyc);
        checkCount++;
        if (!ok || cyc != 3) begin errorCount++; $display("[TB] FAIL basic_latency: got %0d expected 3", cyc); end
        checkCount++;
        if (c[0] !== 16'h0100) begin errorCount++; $display("[TB] FAIL basic_c0_const: got %h expected 0100", c[0]); end
        e = expQ.pop_front();
        for (int k = 0; k < SZ; k++) begin
            checkCount++;
            if (c[k] !== e[k]) begin errorCount++; $display("[TB] FAIL basic_c%0d: got %h expected %h", k, c[k], e[k]); end
        end
        handshake();
    endtask

    task automatic test_negative_bias();
        bit ok;
        int cyc;
        logic [SZ-1:0][15:0] e;
        vecB = '{16'h0000, 16'h8100, 16'h0200};
        beatX[0] = 16'h0100; beatW[0] = '{16'h0100, 16'h0080, 16'h8080};
        push_expected(1);
        drive_beats(1, 1'b1, ok);
        wait_out(ok, cyc);
        checkCount++;
        if (!ok || cyc != 3) begin errorCount++; $display("[TB] FAIL negbias_latency: got %0d expected 3", cyc); end
        checkCount++;
        if (c[1] !== 16'h8080) begin errorCount++; $display("[TB] FAIL negbias_c1_const: got %h expected 8080", c[1]); end
        e = expQ.pop_front();
        for (int k = 0; k < SZ; k++) begin
            checkCount++;
            if (c[k] !== e[k]) begin errorCount++; $display("[TB] FAIL negbias_c%0d: got %h expected %h", k, c[k], e[k]); end
        end
        handshake();
    endtask

    task automatic test_saturation();
        bit ok;
        int cyc;
        logic [SZ-1:0][15:0] e;
        sm_t xs [3];
        sm_t ws [3][SZ];
        sm_t cst [3];
        int  idx [3];
        xs  = '{16'h7F00, 16'h7F00, 16'h8000};
        ws  = '{'{16'h0100, 16'h0000, 16'h7F00},
                '{16'h8100, 16'h0080, 16'hFF00},
                '{16'h0100, 16'h0100, 16'h8100}};
        cst = '{16'h7FFF, 16'hFFFF, 16'h0000};
        idx = '{2, 2, 0};
        vecB = '{16'h0000, 16'h0000, 16'h0000};
        for (int t = 0; t < 3; t++) begin
            beatX[0] = xs[t];
            beatW[0] = ws[t];
            push_expected(1);
            drive_beats(1, 1'b1, ok);
            wait_out(ok, cyc);
            checkCount++;
            if (!ok) begin errorCount++; $display("[TB] FAIL sat%0d_timeout: got no out_valid expected out_valid", t); end
            checkCount++;
            if (c[idx[t]] !== cst[t]) begin errorCount++; $display("[TB] FAIL sat%0d_const: got %h expected %h", t, c[idx[t]], cst[t]); end
            e = expQ.pop_front();
            for (int k = 0; k < SZ; k++) begin
                checkCount++;
                if (c[k] !== e[k]) begin errorCount++; $display("[TB] FAIL sat%0d_c%0d: got %h expected %h", t, k, c[k], e[k]); end
            end
            handshake();
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int cyc;
        logic [SZ-1:0][15:0] e;
        vecB = '{16'h0080, 16'h8040, 16'h0000};
        beatX[0] = 16'h0180; beatW[0] = '{16'h0200, 16'h0100, 16'h8300};
        beatX[1] = 16'h8100; beatW[1] = '{16'h0100, 16'h0240, 16'h0100};
        beatX[2] = 16'h0040; beatW[2] = '{16'h8400, 16'h0010, 16'h0800};
        push_expected(3);
        drive_beats(3, 1'b1, ok);
        wait_out(ok, cyc);
        checkCount++;
        if (!ok || cyc != 3) begin errorCount++; $display("[TB] FAIL bp_latency: got %0d expected 3", cyc); end
        e = expQ.pop_front();
        for (int t = 0; t < 5; t++) begin
            for (int k = 0; k < SZ; k++) begin
                checkCount++;
                if (c[k] !== e[k]) begin errorCount++; $display("[TB] FAIL bp_hold_c%0d: got %h expected %h", k, c[k], e[k]); end
            end
            checkCount++;
            if (out_valid !== 1'b1) begin errorCount++; $display("[TB] FAIL bp_out_valid: got %b expected 1", out_valid); end
            checkCount++;
            if (in_ready !== 1'b0) begin errorCount++; $display("[TB] FAIL bp_in_ready: got %b expected 0", in_ready); end
            @(negedge clk);
        end
        handshake();
        @(negedge clk);
        checkCount++;
        if (in_ready !== 1'b1) begin errorCount++; $display("[TB] FAIL bp_ready_after: got %b expected 1", in_ready); end
        checkCount++;
        if (out_valid !== 1'b0) begin errorCount++; $display("[TB] FAIL bp_valid_after: got %b expected 0", out_valid); end
    endtask

    task automatic test_reset_mid_vector();
        bit ok;
        int cyc;
        logic [SZ-1:0][15:0] e;
        vecB = '{16'h0300, 16'h8200, 16'h0100};
        beatX[0] = 16'h0300; beatW[0] = '{16'h0200, 16'h0200, 16'h0200};
        beatX[1] = 16'h0300; beatW[1] = '{16'h0200, 16'h0200, 16'h0200};
        drive_beats(2, 1'b0, ok);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checkCount++;
        if (out_valid !== 1'b0) begin errorCount++; $display("[TB] FAIL midrst_out_valid: got %b expected 0", out_valid); end
        vecB = '{16'h0000, 16'h0000, 16'h0000};
        beatX[0] = 16'h0100; beatW[0] = '{16'h0100, 16'h0100, 16'h0100};
        push_expected(1);
        drive_beats(1, 1'b1, ok);
        wait_out(ok, cyc);
        checkCount++;
        if (!ok || cyc != 3) begin errorCount++; $display("[TB] FAIL midrst_latency: got %0d expected 3", cyc); end
        e = expQ.pop_front();
        for (int k = 0; k < SZ; k++) begin
            checkCount++;
            if (c[k] !== 16'h0100) begin errorCount++; $display("[TB] FAIL midrst_c%0d_const: got %h expected 0100", k, c[k]); end
            checkCount++;
            if (c[k] !== e[k]) begin errorCount++; $display("[TB] FAIL midrst_c%0d: got %h expected %h", k, c[k], e[k]); end
        end
        handshake();
    endtask

    task automatic test_back_to_back();
        bit ok;
        int cyc;
        logic [SZ-1:0][15:0] e;
        vecB = '{16'h0100, 16'h0000, 16'h8080};
        beatX[0] = 16'h0200; beatW[0] = '{16'h0100, 16'h8100, 16'h0040};
        beatX[1] = 16'h0100; beatW[1] = '{16'h0300, 16'h0080, 16'h0100};
        push_expected(2);
        drive_beats(2, 1'b1, ok);
        vecB = '{16'h8200, 16'h0100, 16'h0000};
        beatX[0] = 16'h0100; beatW[0] = '{16'h0100, 16'h0100, 16'h8200};
        push_expected(1);
        in_valid = 1'b1;
        in_last  = 1'b1;
        x        = beatX[0];
        for (int k = 0; k < SZ; k++) begin
            w[k] = beatW[0][k];
            b[k] = vecB[k];
        end
        ok = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            checkCount++;
            if (in_ready !== 1'b0) begin errorCount++; $display("[TB] FAIL b2b_ready_early: got %b expected 0", in_ready); end
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        checkCount++;
        if (!ok) begin errorCount++; $display("[TB] FAIL b2b_first_timeout: got no out_valid expected out_valid"); end
        e = expQ.pop_front();
        for (int k = 0; k < SZ; k++) begin
            checkCount++;
            if (c[k] !== e[k]) begin errorCount++; $display("[TB] FAIL b2b_v1_c%0d: got %h expected %h", k, c[k], e[k]); end
        end
        handshake();
        @(negedge clk);
        checkCount++;
        if (in_ready !== 1'b1) begin errorCount++; $display("[TB] FAIL b2b_ready_after: got %b expected 1", in_ready); end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        wait_out(ok, cyc);
        checkCount++;
        if (!ok || cyc != 3) begin errorCount++; $display("[TB] FAIL b2b_v2_latency: got %0d expected 3", cyc); end
        e = expQ.pop_front();
        for (int k = 0; k < SZ; k++) begin
            checkCount++;
            if (c[k] !== e[k]) begin errorCount++; $display("[TB] FAIL b2b_v2_c%0d: got %h expected %h", k, c[k], e[k]); end
        end
        handshake();
    endtask

    initial begin
        for (int k = 0; k < SZ; k++) begin
            w[k] = '0;
            b[k] = '0;
        end
        test_reset();
        test_basic();
        test_negative_bias();
        test_saturation();
        test_backpressure();
        test_reset_mid_vector();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
